// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared constants and helpers for the FM modulator core
package fm_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16+x^14+x^13+x^11, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam longint F_S_DEF = 64'sd50_000_000;
  localparam longint F_C_DEF = 64'sd10_000_000;
  localparam longint DF_DEF  = 64'sd75_000;

  typedef enum logic [1:0] {
    Q_RISE    = 2'b00,
    Q_FALL    = 2'b01,
    Q_DIP     = 2'b10,
    Q_RECOVER = 2'b11
  } quadrant_e;

  // Rounded phase increment for frequency f_x at sample rate f_s with an n-bit accumulator
  function automatic int unsigned calc_inc(longint f_s, longint f_x, int n);
    return 32'(((f_x << n) + f_s / 64'sd2) / f_s);
  endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// rtl/fm_sine_lut.sv - quarter-wave sine table with quadrant mirroring, registered output
module fm_sine_lut import fm_pkg::*; #(
  parameter int M = 5,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] idx,
  output logic [D-1:0] rf
);

  localparam int     QN      = 2 ** (M - 2);
  localparam longint ONE     = 64'sd1 << 30;
  localparam longint HALF_PI = 64'sd1686629713;

  // Fixed-point Taylor series; far more precision than the final rounding needs
  function automatic logic [D-1:0] quarter_val(int j);
    longint x, x2, term, s, num;
    x    = (HALF_PI * (64'sd2 * longint'(j) + 64'sd1)) / (64'sd2 * longint'(QN));
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (longint k = 1; k <= 12; k++) begin
      term = -((term * x2) >>> 30) / ((64'sd2 * k) * (64'sd2 * k + 64'sd1));
      s    = s + term;
    end
    num = (((64'sd1 <<< D) - 64'sd1) * (ONE + s) + ONE) >>> 31;
    return D'(num);
  endfunction

  logic [D-1:0] qtab [QN];

  for (genvar g = 0; g < QN; g++) begin : g_qtab
    assign qtab[g] = quarter_val(g);
  end

  quadrant_e    quad;
  logic [M-3:0] addr;
  logic [D-1:0] mag;
  logic [D-1:0] val;

  always_comb begin
    quad = quadrant_e'(idx[M-1:M-2]);
    addr = idx[M-3:0];
    val  = '0;
    if (quad == Q_FALL || quad == Q_RECOVER) begin
      addr = ~idx[M-3:0];
    end
    mag = qtab[addr];
    // Lower half is the complement: (2^D-1) - upper value
    case (quad)
      Q_RISE, Q_FALL: val = mag;
      default:        val = ~mag;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf <= '0;
    end else begin
      rf <= val;
    end
  end

endmodule

// File: rtl/fm_modulator_shadowed.sv
// rtl/fm_modulator_shadowed.sv - FM modulator: audio scaling, shadowed config, dithered phase accumulator
module fm_modulator_shadowed import fm_pkg::*; #(
  parameter int          A            = 8,
  parameter int          L            = 12,
  parameter int          N            = 18,
  parameter int          M            = 5,
  parameter int          D            = 4,
  parameter int unsigned ACC_RST      = calc_inc(F_S_DEF, F_C_DEF, N),
  parameter int unsigned DF_RST       = calc_inc(F_S_DEF, DF_DEF, N),
  parameter int          UNDERRUN_TMO = 4096,
  parameter int          CFG_TMO      = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [A-1:0] audio_in,
  input  logic                audio_valid,
  input  logic        [N-1:0] acc_inc,
  input  logic        [L-1:0] df_inc,
  input  logic                cfg_load,
  input  logic        [2:0]   dith_fact,
  output logic        [D-1:0] rf,
  output logic        [N-1:0] freq_word,
  output logic                underrun,
  output logic                cfg_pending
);

  localparam int PW  = A + L + 1;
  localparam int DW  = N - M;
  localparam int REP = (DW + 15) / 16;
  localparam int UW  = $clog2(UNDERRUN_TMO);
  localparam int CW  = $clog2(CFG_TMO);

  logic signed [A-1:0]  aud_r;
  logic signed [PW-1:0] prod_r;
  logic        [N-1:0]  fw_delta;
  logic        [N-1:0]  acc_a;
  logic        [N-1:0]  pend_acc;
  logic        [L-1:0]  df_a;
  logic        [L-1:0]  pend_df;
  logic        [N-1:0]  phase;
  logic        [N:0]    phase_sum;
  logic        [N-1:0]  dith;
  logic        [DW-1:0] dith_src;
  logic        [M-1:0]  lut_idx;
  logic        [15:0]   lfsr;
  logic        [15:0]   lfsr_next;
  logic        [UW-1:0] ur_cnt;
  logic        [CW-1:0] cfg_cnt;
  logic                 wrap;
  logic                 ur_hit;
  logic                 cfg_apply;

  // Scaled deviation, floor-divided by 2^(A-1) and fitted to the accumulator width
  assign fw_delta  = N'(prod_r >>> (A - 1));
  assign phase_sum = {1'b0, phase} + {1'b0, freq_word};
  assign wrap      = phase_sum[N];

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign dith_src  = DW'({REP{lfsr}});
  assign dith      = (dith_fact == 3'd0) ? '0 : N'(dith_src >> (3'd7 - dith_fact));
  assign lut_idx   = M'((phase + dith) >> DW);

  assign ur_hit    = !audio_valid && (ur_cnt == UW'(UNDERRUN_TMO - 1));
  // Config swaps at phase wrap so the carrier changes glitch-free; timeout bounds the wait
  assign cfg_apply = cfg_pending && (wrap || (cfg_cnt == CW'(CFG_TMO - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      aud_r       <= '0;
      prod_r      <= '0;
      freq_word   <= N'(ACC_RST);
      phase       <= '0;
      underrun    <= 1'b0;
      cfg_pending <= 1'b0;
      acc_a       <= N'(ACC_RST);
      df_a        <= L'(DF_RST);
      pend_acc    <= '0;
      pend_df     <= '0;
      lfsr        <= LFSR_SEED;
      ur_cnt      <= '0;
      cfg_cnt     <= '0;
    end else begin
      lfsr      <= lfsr_next;
      prod_r    <= PW'(aud_r) * PW'($signed({1'b0, df_a}));
      freq_word <= acc_a + fw_delta;
      phase     <= phase_sum[N-1:0];

      if (audio_valid) begin
        aud_r    <= audio_in;
        ur_cnt   <= '0;
        underrun <= 1'b0;
      end else if (ur_hit) begin
        aud_r    <= '0;
        underrun <= 1'b1;
      end else begin
        ur_cnt <= ur_cnt + UW'(1);
      end

      if (cfg_apply) begin
        acc_a <= pend_acc;
        df_a  <= pend_df;
      end

      // A load on the apply edge queues behind the values being applied
      if (cfg_load) begin
        pend_acc    <= acc_inc;
        pend_df     <= df_inc;
        cfg_pending <= 1'b1;
        cfg_cnt     <= '0;
      end else if (cfg_apply) begin
        cfg_pending <= 1'b0;
        cfg_cnt     <= '0;
      end else if (cfg_pending) begin
        cfg_cnt <= cfg_cnt + CW'(1);
      end
    end
  end

  fm_sine_lut #(
    .M(M),
    .D(D)
  ) u_lut (
    .clk(clk),
    .rst(rst),
    .idx(lut_idx),
    .rf (rf)
  );

endmodule

// File: tb/tb_fm_modulator_shadowed.sv
// tb/tb_fm_modulator_shadowed.sv - randomized self-checking bench against a behavioural FM model
module tb_fm_modulator_shadowed;

  localparam int     A       = 8;
  localparam int     L       = 12;
  localparam int     N       = 18;
  localparam int     M       = 5;
  localparam int     D       = 4;
  localparam int     UR_TMO  = 8;
  localparam int     CFG_TMO = 64;
  localparam longint P       = 64'sd1 << N;
  localparam longint ACC_DEF = 52429;
  localparam longint DF_DEF  = 393;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [A-1:0] audio_in = '0;
  logic               audio_valid = 1'b0;
  logic [N-1:0]       acc_inc = '0;
  logic [L-1:0]       df_inc = '0;
  logic               cfg_load = 1'b0;
  logic [2:0]         dith_fact = 3'd0;
  logic [D-1:0]       rf;
  logic [N-1:0]       freq_word;
  logic               underrun;
  logic               cfg_pending;

  always #5 clk = ~clk;

  fm_modulator_shadowed #(
    .UNDERRUN_TMO(UR_TMO),
    .CFG_TMO     (CFG_TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .audio_in   (audio_in),
    .audio_valid(audio_valid),
    .acc_inc    (acc_inc),
    .df_inc     (df_inc),
    .cfg_load   (cfg_load),
    .dith_fact  (dith_fact),
    .rf         (rf),
    .freq_word  (freq_word),
    .underrun   (underrun),
    .cfg_pending(cfg_pending)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int     lut_ref [32];
  longint m_aud, m_prod, m_fw, m_phase, m_rf, m_ur, m_urcnt;
  longint m_pend, m_pacc, m_pdf, m_ccnt, m_acc, m_df, m_lfsr;

  function automatic longint floor_div(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic longint wrapn(input longint x);
    return ((x % P) + P) % P;
  endfunction

  // Next state of the whole modulator given the inputs presented before the coming edge
  task automatic model_step();
    longint sum, dith, fw_n, prod_n, phase_n, rf_n, lfsr_n;
    bit     wrap, apply;
    if (rst) begin
      m_aud = 0; m_prod = 0; m_fw = ACC_DEF; m_phase = 0; m_rf = 0;
      m_ur = 0; m_urcnt = 0; m_pend = 0; m_ccnt = 0;
      m_acc = ACC_DEF; m_df = DF_DEF; m_lfsr = 'hACE1;
    end else begin
      sum     = m_phase + m_fw;
      wrap    = (sum >= P);
      apply   = (m_pend == 1) && (wrap || m_ccnt == CFG_TMO - 1);
      dith    = (dith_fact == 0) ? 0 : (m_lfsr % 8192) / (64'sd1 << (7 - int'(dith_fact)));
      rf_n    = lut_ref[int'(((m_phase + dith) % P) / (P / 32))];
      phase_n = sum % P;
      fw_n    = wrapn(m_acc + floor_div(m_prod, 128));
      prod_n  = m_aud * m_df;
      lfsr_n  = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
      if (audio_valid) begin
        m_aud = longint'(audio_in); m_urcnt = 0; m_ur = 0;
      end else if (m_urcnt == UR_TMO - 1) begin
        m_aud = 0; m_ur = 1;
      end else begin
        m_urcnt++;
      end
      if (apply) begin
        m_acc = m_pacc; m_df = m_pdf;
      end
      if (cfg_load) begin
        m_pacc = longint'(acc_inc); m_pdf = longint'(df_inc); m_pend = 1; m_ccnt = 0;
      end else if (apply) begin
        m_pend = 0; m_ccnt = 0;
      end else if (m_pend == 1) begin
        m_ccnt++;
      end
      m_rf = rf_n; m_phase = phase_n; m_fw = fw_n; m_prod = prod_n; m_lfsr = lfsr_n;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rf", 64'(rf), m_rf);
    chk("freq_word", 64'(freq_word), m_fw);
    chk("underrun", 64'(underrun), m_ur);
    chk("cfg_pending", 64'(cfg_pending), m_pend);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_cfg(input longint acc, input longint df);
    acc_inc  = N'(acc);
    df_inc   = L'(df);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic strobe(input int s);
    audio_in    = A'(s);
    audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
  endtask

  task automatic wait_apply(input int limit);
    int k = 0;
    while (cfg_pending && k < limit) begin
      tick();
      k++;
    end
    chk("apply_bound", 64'(cfg_pending), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 32; i++) begin
      lut_ref[i] = $rtoi($floor(((2.0 ** D) - 1.0) / 2.0 *
                   (1.0 + $sin(2.0 * 3.14159265358979 * (i + 0.5) / 32.0)) + 0.5));
    end

    // reset and default carrier
    rst = 1'b1;
    run(3);
    chk("rst_fw", 64'(freq_word), 64'd52429);
    chk("rst_rf", 64'(rf), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_pending", 64'(cfg_pending), 64'd0);
    rst = 1'b0;
    run(10);
    chk("run_fw", 64'(freq_word), 64'd52429);
    do_cfg(12345, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pending", 64'(cfg_pending), 64'd0);
    chk("midrst_fw", 64'(freq_word), 64'd52429);
    run(20);
    chk("midrst_discard", 64'(freq_word), 64'd52429);

    // pure carrier at quarter-rate index step
    do_cfg(65536, 0);
    wait_apply(100);
    run(3);
    chk("t2_fw", 64'(freq_word), 64'd65536);
    run(12);

    // deviation scaling, both extremes
    do_cfg(1000, 4095);
    wait_apply(100);
    run(3);
    strobe(127);
    run(2);
    chk("t3_fw_pos", 64'(freq_word), 64'd5063);

    // underrun after UR_TMO idle cycles
    run(5);
    chk("t4_ur_pre", 64'(underrun), 64'd0);
    tick();
    chk("t4_ur_set", 64'(underrun), 64'd1);
    run(2);
    chk("t4_fw_idle", 64'(freq_word), 64'd1000);
    strobe(-128);
    chk("t4_ur_clr", 64'(underrun), 64'd0);
    run(2);
    chk("t3_fw_neg", 64'(freq_word), 64'd259049);

    // timeout apply with a frozen phase
    do_cfg(0, 0);
    wait_apply(200);
    run(12);
    chk("t5_fw_zero", 64'(freq_word), 64'd0);
    do_cfg(4096, 0);
    cnt = 0;
    while (cfg_pending && cnt < 4 * CFG_TMO) begin
      cnt++;
      tick();
    end
    chk("t5_pend_len", 64'(cnt), 64'(CFG_TMO));
    run(1);
    chk("t5_fw_applied", 64'(freq_word), 64'd4096);

    // last load wins
    do_cfg(0, 0);
    wait_apply(200);
    run(3);
    do_cfg(20000, 0);
    run(3);
    do_cfg(30000, 0);
    run(5);
    chk("t5_hold_fw", 64'(freq_word), 64'd0);
    wait_apply(200);
    run(1);
    chk("t5_lastwin", 64'(freq_word), 64'd30000);

    // load on the apply edge
    do_cfg(0, 0);
    wait_apply(200);
    run(3);
    do_cfg(4096, 0);
    run(CFG_TMO - 1);
    acc_inc  = N'(8192);
    df_inc   = '0;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t5_coinc_pend", 64'(cfg_pending), 64'd1);
    tick();
    chk("t5_coinc_fw", 64'(freq_word), 64'd4096);
    wait_apply(200);
    run(1);
    chk("t5_coinc_last", 64'(freq_word), 64'd8192);

    // dither amplitudes
    do_cfg(65536, 0);
    dith_fact = 3'd0;
    wait_apply(100);
    run(30);
    dith_fact = 3'd7;
    run(60);
    dith_fact = 3'd3;
    run(30);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      audio_valid = ($urandom_range(0, 3) == 0);
      audio_in    = A'($urandom);
      cfg_load    = ($urandom_range(0, 49) == 0);
      acc_inc     = N'($urandom);
      df_inc      = L'($urandom);
      if (c % 100 == 0) dith_fact = 3'($urandom);
      rst = (c == 700);
      tick();
    end
    rst         = 1'b0;
    audio_valid = 1'b0;
    cfg_load    = 1'b0;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
